// File: rtl/ppm_rx_ctrl.sv
// rtl/ppm_rx_ctrl.sv - 1-of-4 PPM receive frame controller (optional PPM_RX_BYTECNT_EN adds rx_byte_cnt)
module ppm_rx_ctrl #(
  parameter int SLOT_CLKS = 16,
  parameter int MAX_BYTES = 32
) (
  input  logic       clk16,
  input  logic       rst_n,
  input  logic       Din,
  input  logic       sof_rcv_in,
  output logic       eof_rcv_out,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       frame_done,
  output logic       frame_err,
`ifdef PPM_RX_BYTECNT_EN
  output logic [7:0] rx_byte_cnt,
`endif
  output logic [1:0] err_code
);

  localparam int CW = $clog2(SLOT_CLKS);
  localparam logic [CW-1:0] SLOT_MID  = CW'(SLOT_CLKS / 2);
  localparam logic [CW-1:0] SLOT_LAST = CW'(SLOT_CLKS - 1);
  localparam logic [7:0]    MAX_B     = 8'(MAX_BYTES);

  typedef enum logic [1:0] {IDLE, RX, DONE, ERR} state_t;

  state_t          state;
  logic            din_m, din_s;
  logic [CW-1:0]   slot_cnt;
  logic [1:0]      slot_idx;
  logic [1:0]      sym_idx;
  logic [1:0]      pulse_cnt;
  logic [1:0]      first_slot;
  logic [7:0]      byte_acc;
  logic [7:0]      byte_next;
  logic [7:0]      byte_cnt;
  logic            slot_end, sym_end, pulse_now;

`ifdef PPM_RX_BYTECNT_EN
  assign rx_byte_cnt = byte_cnt;
`endif

  assign slot_end  = (state == RX) && (slot_cnt == SLOT_LAST);
  assign sym_end   = slot_end && (slot_idx == 2'd3);
  assign pulse_now = (state == RX) && (slot_cnt == SLOT_MID) && !din_s;

  // Two-flop synchroniser; idle line level is high
  always_ff @(posedge clk16 or negedge rst_n) begin
    if (!rst_n) begin
      din_m <= 1'b1;
      din_s <= 1'b1;
    end else begin
      din_m <= Din;
      din_s <= din_m;
    end
  end

  // Byte under assembly with the current symbol's slot index merged in
  always_comb begin
    byte_next = byte_acc;
    byte_next[{sym_idx, 1'b0} +: 2] = first_slot;
  end

  // Frame FSM, slot timing, symbol decode and output holding register
  always_ff @(posedge clk16 or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      slot_cnt    <= '0;
      slot_idx    <= '0;
      sym_idx     <= '0;
      pulse_cnt   <= '0;
      first_slot  <= '0;
      byte_acc    <= '0;
      byte_cnt    <= '0;
      out_data    <= '0;
      out_valid   <= 1'b0;
      frame_done  <= 1'b0;
      frame_err   <= 1'b0;
      eof_rcv_out <= 1'b0;
      err_code    <= 2'b00;
    end else begin
      frame_done  <= 1'b0;
      frame_err   <= 1'b0;
      eof_rcv_out <= 1'b0;
      if (out_valid && out_ready) out_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (sof_rcv_in) begin
            state      <= RX;
            slot_cnt   <= '0;
            slot_idx   <= '0;
            sym_idx    <= '0;
            pulse_cnt  <= '0;
            first_slot <= '0;
            byte_acc   <= '0;
            byte_cnt   <= '0;
            err_code   <= 2'b00;
          end
        end
        RX: begin
          slot_cnt <= slot_cnt + 1'b1;
          if (slot_end) slot_idx <= slot_idx + 1'b1;
          if (pulse_now) begin
            if (pulse_cnt == 2'd0) first_slot <= slot_idx;
            if (pulse_cnt != 2'd2) pulse_cnt <= pulse_cnt + 1'b1;
          end
          if (sym_end) begin
            pulse_cnt <= '0;
            if (pulse_cnt == 2'd2) begin
              state       <= ERR;
              err_code    <= 2'b01;
              frame_err   <= 1'b1;
              eof_rcv_out <= 1'b1;
            end else if (pulse_cnt == 2'd1) begin
              byte_acc <= byte_next;
              sym_idx  <= sym_idx + 1'b1;
              if (sym_idx == 2'd3) begin
                if ((out_valid && !out_ready) || (byte_cnt == MAX_B)) begin
                  state       <= ERR;
                  err_code    <= 2'b11;
                  frame_err   <= 1'b1;
                  eof_rcv_out <= 1'b1;
                end else begin
                  out_data  <= byte_next;
                  out_valid <= 1'b1;
                  byte_cnt  <= byte_cnt + 8'd1;
                end
              end
            end else if ((sym_idx == 2'd0) && (byte_cnt != 8'd0)) begin
              state       <= DONE;
              frame_done  <= 1'b1;
              eof_rcv_out <= 1'b1;
            end else begin
              state       <= ERR;
              err_code    <= 2'b10;
              frame_err   <= 1'b1;
              eof_rcv_out <= 1'b1;
            end
          end
        end
        DONE:    state <= IDLE;
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ppm_rx_ctrl.sv
// tb/tb_ppm_rx_ctrl.sv - table-driven bench for ppm_rx_ctrl
module tb_ppm_rx_ctrl;

  logic       clk16 = 1'b0;
  logic       rst_n;
  logic       Din;
  logic       sof_rcv_in;
  logic       eof_rcv_out;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       frame_done;
  logic       frame_err;
  logic [1:0] err_code;
`ifdef PPM_RX_BYTECNT_EN
  logic [7:0] rx_byte_cnt;
`endif

  always #5 clk16 = ~clk16;

  ppm_rx_ctrl #(.SLOT_CLKS(16), .MAX_BYTES(2)) dut (
    .clk16(clk16), .rst_n(rst_n), .Din(Din), .sof_rcv_in(sof_rcv_in),
    .eof_rcv_out(eof_rcv_out), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .frame_done(frame_done), .frame_err(frame_err),
`ifdef PPM_RX_BYTECNT_EN
    .rx_byte_cnt(rx_byte_cnt),
`endif
    .err_code(err_code)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int n_done = 0, n_err = 0, n_eof = 0;
  logic [7:0] rxq[$];

  // Monitor: records accepted bytes and counts end-of-frame pulses
  always @(negedge clk16) begin
    #2;
    if (rst_n) begin
      if (out_valid && out_ready) rxq.push_back(out_data);
      if (frame_done) n_done++;
      if (frame_err) n_err++;
      if (eof_rcv_out) n_eof++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(negedge clk16);
  endtask

  task automatic send_sof();
    sof_rcv_in = 1'b1;
    step(1);
    sof_rcv_in = 1'b0;
  endtask

  // mask bit k set means a low pulse during slot k of this symbol
  task automatic send_sym(input logic [3:0] mask);
    for (int c = 0; c < 64; c++) begin
      Din = !mask[c / 16];
      step(1);
    end
    Din = 1'b1;
  endtask

  typedef struct {
    logic [47:0] syms;   // nibble i = slot mask of symbol i
    int          nsym;
    int          nbytes;
    logic [7:0]  b0;
    logic [7:0]  b1;
    int          ndone;
    int          nerr;
    logic [1:0]  code;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int base_q, d0, e0, f0;

    vecs[0] = '{48'h04821,        5,  1, 8'hB4, 8'h00, 1, 0, 2'b00}; // slots 0,1,3,2 then EOF
    vecs[1] = '{48'h088881111,    9,  2, 8'h00, 8'hFF, 1, 0, 2'b00}; // 0x00, 0xFF, EOF
    vecs[2] = '{48'h6,            1,  0, 8'h00, 8'h00, 0, 1, 2'b01}; // slots 1 and 2 together
    vecs[3] = '{48'h011,          3,  0, 8'h00, 8'h00, 0, 1, 2'b10}; // empty after 2 symbols
    vecs[4] = '{48'h0,            1,  0, 8'h00, 8'h00, 0, 1, 2'b10}; // empty first symbol
    vecs[5] = '{48'h111188881111, 12, 2, 8'h00, 8'hFF, 0, 1, 2'b11}; // third byte exceeds MAX_BYTES=2
    vecs[6] = '{48'h9111,         4,  0, 8'h00, 8'h00, 0, 1, 2'b01}; // two pulses in 4th symbol

    rst_n = 1'b0; Din = 1'b1; sof_rcv_in = 1'b0; out_ready = 1'b1;
    step(3);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_eof", eof_rcv_out, 0);
    check("rst_err_code", err_code, 0);
    rst_n = 1'b1;
    step(2);

    for (int v = 0; v < 7; v++) begin
      base_q = rxq.size(); d0 = n_done; e0 = n_err; f0 = n_eof;
      out_ready = 1'b1;
      send_sof();
      for (int s = 0; s < vecs[v].nsym; s++) send_sym(vecs[v].syms[4*s +: 4]);
      step(8);
      check($sformatf("v%0d_nbytes", v), rxq.size() - base_q, vecs[v].nbytes);
      if (vecs[v].nbytes >= 1 && rxq.size() > base_q)
        check($sformatf("v%0d_byte0", v), rxq[base_q], vecs[v].b0);
      if (vecs[v].nbytes >= 2 && rxq.size() > base_q + 1)
        check($sformatf("v%0d_byte1", v), rxq[base_q + 1], vecs[v].b1);
      check($sformatf("v%0d_done", v), n_done - d0, vecs[v].ndone);
      check($sformatf("v%0d_err", v), n_err - e0, vecs[v].nerr);
      check($sformatf("v%0d_eof", v), n_eof - f0, vecs[v].ndone + vecs[v].nerr);
      check($sformatf("v%0d_code", v), err_code, vecs[v].code);
      check($sformatf("v%0d_valid_idle", v), out_valid, 0);
`ifdef PPM_RX_BYTECNT_EN
      if (v == 1) check("v1_rx_byte_cnt", rx_byte_cnt, 2);
`endif
    end

    // Back-pressure: second byte completes while first is still held
    base_q = rxq.size(); e0 = n_err;
    out_ready = 1'b0;
    send_sof();
    send_sym(4'h8); send_sym(4'h4); send_sym(4'h2); send_sym(4'h1);
    step(1);
    check("bp_valid", out_valid, 1);
    check("bp_data", out_data, 8'h1B);
    send_sym(4'h1); send_sym(4'h1);
    check("bp_data_stable", out_data, 8'h1B);
    send_sym(4'h1); send_sym(4'h1);
    step(8);
    check("bp_err", n_err - e0, 1);
    check("bp_code", err_code, 2'b11);
    check("bp_held_valid", out_valid, 1);
    check("bp_held_data", out_data, 8'h1B);
    check("bp_no_xfer", rxq.size() - base_q, 0);
    out_ready = 1'b1;
    step(2);
    check("bp_delivered_n", rxq.size() - base_q, 1);
    if (rxq.size() > base_q) check("bp_delivered", rxq[base_q], 8'h1B);
    check("bp_valid_clr", out_valid, 0);

    // Asynchronous reset mid-byte with a held byte pending
    out_ready = 1'b0;
    send_sof();
    send_sym(4'h8); send_sym(4'h4); send_sym(4'h2); send_sym(4'h1);
    send_sym(4'h1); send_sym(4'h2);
    #3 rst_n = 1'b0;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_data", out_data, 0);
    check("arst_code", err_code, 0);
    check("arst_done", frame_done, 0);
    check("arst_err", frame_err, 0);
    check("arst_eof", eof_rcv_out, 0);
    step(2);
    rst_n = 1'b1;
    out_ready = 1'b1;
    step(2);
    base_q = rxq.size(); d0 = n_done;
    send_sof();
    send_sym(4'h4); send_sym(4'h4); send_sym(4'h2); send_sym(4'h2); send_sym(4'h0);
    step(8);
    check("post_rst_nbytes", rxq.size() - base_q, 1);
    if (rxq.size() > base_q) check("post_rst_byte", rxq[base_q], 8'h5A);
    check("post_rst_done", n_done - d0, 1);
    check("post_rst_code", err_code, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ppm_rx_ctrl.md
Name: ppm_rx_ctrl

Overview:
Receive-frame controller for the 1-out-of-4 PPM decoder, running on the 16x oversampling clock clk16. It is started by the SOF detector's sof_rcv pulse and times symbol slots on Din. It decodes slot positions into 2-bit symbols, assembles bytes and hands them out over a valid/ready interface. It ends the frame on EOF or error and returns eof_rcv_out to the SOF detector to re-arm it.

Parameters:
SLOT_CLKS, 16, clk16 cycles per PPM slot; power of 2, >=4
MAX_BYTES, 32, maximum payload bytes per frame; 1..255

Ports:
clk16  input  1  16x oversampling clock
rst_n  input  1  asynchronous active-low reset
Din  input  1  raw PPM line, active-low pulse
sof_rcv_in  input  1  single-cycle SOF detected, from SOF detector
eof_rcv_out  output  1  single-cycle frame end (good or bad), to SOF detector eof_rcv_in
out_data  output  8  received byte
out_valid  output  1  out_data valid
out_ready  input  1  downstream accepts byte
frame_done  output  1  single-cycle good-frame end pulse
frame_err  output  1  single-cycle error pulse
err_code  output  2  01 multi-pulse, 10 bad EOF position, 11 overflow/too long; holds until next SOF

Behaviour:
- Reset: all outputs 0; state IDLE; counters 0; holding register empty.
- Din is double-flop synchronised to din_s. A pulse is din_s==0 sampled at slot_cnt==SLOT_CLKS/2.
- States are IDLE, RX, DONE and ERR.
- IDLE:
  - Wait for sof_rcv_in.
  - On sof_rcv_in, next cycle enter RX with slot_cnt=0, slot_idx=0, sym_idx=0, byte_cnt=0, err_code=00.
- RX timing:
  - slot_cnt counts 0..SLOT_CLKS-1 and wraps.
  - slot_idx (0..3) increments on each slot_cnt wrap.
  - Per symbol window, record pulse count (saturating at 2) and the slot_idx of the first pulse.
- Symbol evaluation occurs on the cycle where slot_idx==3 and slot_cnt==SLOT_CLKS-1:
  - Exactly 1 pulse: shift the slot index into the byte, LSB pair first, with bits[1:0] from symbol 0. sym_idx increments.
  - 2+ pulses: go to ERR, err_code=01.
  - 0 pulses with sym_idx==0 and byte_cnt>=1: go to DONE (EOF).
  - 0 pulses otherwise: go to ERR, err_code=10.
- After the 4th symbol the byte loads into the holding register. out_valid asserts the next cycle and byte_cnt increments.
- If a byte completes while out_valid=1 and out_ready=0: go to ERR, err_code=11; the held byte is kept.
- If byte_cnt would exceed MAX_BYTES: go to ERR, err_code=11.
- Handshake:
  - Transfer occurs when out_valid and out_ready are both high.
  - out_valid clears the cycle after a transfer unless a new byte loads that same cycle, in which case it stays 1 with the new data.
  - out_data is stable while out_valid=1 and out_ready=0.
- DONE: one cycle with frame_done=1 and eof_rcv_out=1, then IDLE. A pending held byte remains valid until accepted.
- ERR: one cycle with frame_err=1 and eof_rcv_out=1, then IDLE. The holding register is not flushed.
- sof_rcv_in while in RX, DONE or ERR is ignored.
- Async reset mid-frame clears everything immediately, including the held byte.

Optional Feature:
- PPM_RX_BYTECNT_EN defined:
  - Adds output rx_byte_cnt [7:0], the running byte_cnt.
  - Value is frozen at frame end and cleared on the next accepted SOF.
- Undefined: port is absent and byte_cnt is internal only.

Test Plan:
- Reset, then SOF, then symbols with slots 0,1,3,2 (byte 0xB4), then an empty symbol → out_valid with out_data=0xB4; frame_done and eof_rcv_out pulse once; err_code=00.
- Two bytes 0x00 and 0xFF with out_ready tied 1 → two out_valid transfers of 0x00 then 0xFF; byte_cnt=2; frame_done pulses.
- Pulses in slot 1 and slot 2 of the same symbol → frame_err and eof_rcv_out pulse; err_code=01; no byte emitted.
- Empty symbol after only 2 valid symbols → frame_err; err_code=10.
- out_ready=0 across two complete bytes → first byte held stable; frame_err with err_code=11; first byte still delivered when out_ready rises.
- rst_n asserted mid-byte → all outputs 0 immediately; next SOF decodes 0x5A correctly.
